// File: rtl/store_buffer_fifo_pkg.sv
// Shared codebase package: default D-cache line geometry and the store buffer
// entry layout. Blocks with different geometry override the widths through their
// own parameters and keep the same {line, data, be} field order.
package soc;

    localparam int SOC_DCACHE_LINE_BYTES = 16;
    localparam int SOC_ADDR_WIDTH        = 32;
    localparam int SOC_LINE_OFF_W        = $clog2(SOC_DCACHE_LINE_BYTES);

    typedef struct packed {
        logic [SOC_ADDR_WIDTH-SOC_LINE_OFF_W-1:0] line;
        logic [SOC_DCACHE_LINE_BYTES*8-1:0]       data;
        logic [SOC_DCACHE_LINE_BYTES-1:0]         be;
    } st_buf_entry_t;

endpackage

// File: rtl/store_buffer_fifo_fwd_select.sv
// st_buf_fwd_select: per-byte youngest-match priority selector.
// Ports:
//   match_i : per byte, match vector indexed by age (bit 0 = oldest entry)
//   found_o : per byte, at least one entry matched
//   age_o   : per byte, age index of the youngest matching entry
module st_buf_fwd_select #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_BYTES  = 16
) (
    input  logic [DATA_BYTES-1:0][NUM_ENTRIES-1:0]         match_i,
    output logic [DATA_BYTES-1:0]                          found_o,
    output logic [DATA_BYTES-1:0][$clog2(NUM_ENTRIES)-1:0] age_o
);

    localparam int AGE_W = $clog2(NUM_ENTRIES);

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        found_o = '0;
        age_o   = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                age_o[b]   = match_i[b][k] ? AGE_W'(k) : age_o[b];
                found_o[b] = found_o[b] | match_i[b][k];
            end
        end
    end

endmodule

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: in-order circular store buffer between the memory stage and
// the data cache, with youngest-entry coalescing and byte-granular load forwarding.
// Ports:
//   clock, reset (async, active-low)
//   push_*  : store request in (valid/ready, line-positioned data, byte enables)
//   drain_* : oldest entry out to the cache (valid/ready)
//   fwd_*   : combinational load lookup against registered buffer contents
//   empty, full, count : occupancy status
module store_buffer_fifo
    import soc::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = SOC_ADDR_WIDTH,
    parameter int DATA_BYTES  = SOC_DCACHE_LINE_BYTES,
    parameter int COALESCE    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ADDR_WIDTH-1:0]         push_addr,
    input  logic [DATA_BYTES*8-1:0]       push_data,
    input  logic [DATA_BYTES-1:0]         push_be,
    output logic                          drain_valid,
    input  logic                          drain_ready,
    output logic [ADDR_WIDTH-1:0]         drain_addr,
    output logic [DATA_BYTES*8-1:0]       drain_data,
    output logic [DATA_BYTES-1:0]         drain_be,
    input  logic                          fwd_valid,
    input  logic [ADDR_WIDTH-1:0]         fwd_addr,
    input  logic [DATA_BYTES-1:0]         fwd_be,
    output logic                          fwd_hit,
    output logic                          fwd_partial,
    output logic [DATA_BYTES*8-1:0]       fwd_data,
    output logic [DATA_BYTES-1:0]         fwd_mask,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(NUM_ENTRIES):0]  count
);

    localparam int PTR_W  = $clog2(NUM_ENTRIES);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OFF_W  = $clog2(DATA_BYTES);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    // Same field order as soc::st_buf_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [LINE_W-1:0]         line;
        logic [DATA_BYTES*8-1:0]   data;
        logic [DATA_BYTES-1:0]     be;
    } entry_t;

    entry_t               mem_ff [NUM_ENTRIES];
    entry_t               mem_d  [NUM_ENTRIES];
    logic [PTR_W-1:0]     head_ff, head_d;
    logic [PTR_W-1:0]     tail_ff, tail_d;
    logic [CNT_W-1:0]     count_ff, count_d;

    logic [LINE_W-1:0]    push_line_s;
    logic [LINE_W-1:0]    fwd_line_s;
    logic [PTR_W-1:0]     young_s;
    logic                 full_s;
    logic                 coal_match_s;
    logic                 push_fire_s;
    logic                 drain_fire_s;
    logic                 coal_do_s;
    logic                 alloc_s;
    logic                 unused_s;

    logic [DATA_BYTES-1:0][NUM_ENTRIES-1:0] match_s;
    logic [DATA_BYTES-1:0]                  found_s;
    logic [DATA_BYTES-1:0][PTR_W-1:0]       age_s;

    assign push_line_s = push_addr[ADDR_WIDTH-1:OFF_W];
    assign fwd_line_s  = fwd_addr[ADDR_WIDTH-1:OFF_W];
    assign young_s     = tail_ff - PTR_W'(1);
    assign full_s      = (count_ff == CNT_W'(NUM_ENTRIES));
    // Byte offsets inside a line never select anything: data is line-positioned.
    assign unused_s    = ^{push_addr[OFF_W-1:0], fwd_addr[OFF_W-1:0]};

    // Handshake decode. Coalescing is allowed even when full: a full buffer has at
    // least two entries, so the youngest cannot be the draining head.
    always_comb begin
        coal_match_s = 1'b0;
        if (COALESCE != 0) begin
            coal_match_s = (count_ff != '0) && (mem_ff[young_s].line == push_line_s);
        end else begin
            coal_match_s = 1'b0;
        end
        push_ready   = !full_s || coal_match_s;
        push_fire_s  = push_valid && push_ready;
        drain_fire_s = drain_valid && drain_ready;
        // A single remaining entry that is leaving this cycle must not absorb the store.
        coal_do_s    = push_fire_s && coal_match_s &&
                       !(drain_fire_s && (count_ff == CNT_W'(1)));
        alloc_s      = push_fire_s && !coal_do_s;
    end

    // Next-state for pointers, occupancy and entry contents.
    always_comb begin
        head_d  = head_ff;
        tail_d  = tail_ff;
        count_d = count_ff;
        mem_d   = mem_ff;
        if (drain_fire_s) begin
            head_d = head_ff + PTR_W'(1);
        end else begin
            head_d = head_ff;
        end
        if (coal_do_s) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                mem_d[young_s].data[b*8 +: 8] = push_be[b] ? push_data[b*8 +: 8]
                                                           : mem_ff[young_s].data[b*8 +: 8];
            end
            mem_d[young_s].be = mem_ff[young_s].be | push_be;
        end else if (alloc_s) begin
            mem_d[tail_ff].line = push_line_s;
            mem_d[tail_ff].data = push_data;
            mem_d[tail_ff].be   = push_be;
            tail_d              = tail_ff + PTR_W'(1);
        end else begin
            tail_d = tail_ff;
        end
        case ({alloc_s, drain_fire_s})
            2'b10:   count_d = count_ff + CNT_W'(1);
            2'b01:   count_d = count_ff - CNT_W'(1);
            default: count_d = count_ff;
        endcase
    end

    // Pointer and occupancy registers; reset discards every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ff  <= '0;
            tail_ff  <= '0;
            count_ff <= '0;
        end else begin
            head_ff  <= head_d;
            tail_ff  <= tail_d;
            count_ff <= count_d;
        end
    end

    // Entry storage; validity comes from head/count, so no reset is needed.
    always_ff @(posedge clock) begin
        mem_ff <= mem_d;
    end

    // Status and drain outputs, driven from registered state only.
    always_comb begin
        count = count_ff;
        empty = (count_ff == '0);
        full  = full_s;
        if (count_ff != '0) begin
            drain_valid = 1'b1;
            drain_addr  = {mem_ff[head_ff].line, {OFF_W{1'b0}}};
            drain_data  = mem_ff[head_ff].data;
            drain_be    = mem_ff[head_ff].be;
        end else begin
            drain_valid = 1'b0;
            drain_addr  = '0;
            drain_data  = '0;
            drain_be    = '0;
        end
    end

    // Age-ordered match vectors: age k lives at physical slot head+k.
    always_comb begin
        match_s = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                match_s[b][k] = fwd_valid && fwd_be[b] &&
                                (CNT_W'(k) < count_ff) &&
                                (mem_ff[head_ff + PTR_W'(k)].line == fwd_line_s) &&
                                mem_ff[head_ff + PTR_W'(k)].be[b];
            end
        end
    end

    st_buf_fwd_select #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DATA_BYTES  (DATA_BYTES)
    ) u_fwd_select (
        .match_i (match_s),
        .found_o (found_s),
        .age_o   (age_s)
    );

    // Gather forwarded bytes and summarise the lookup result.
    always_comb begin
        fwd_data = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (found_s[b]) begin
                fwd_data[b*8 +: 8] = mem_ff[head_ff + age_s[b]].data[b*8 +: 8];
            end else begin
                fwd_data[b*8 +: 8] = 8'h00;
            end
        end
        fwd_mask    = found_s;
        fwd_hit     = fwd_valid && (fwd_be != '0) && ((fwd_be & ~found_s) == '0);
        fwd_partial = (found_s != '0) && !fwd_hit;
    end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench: instance A (8 entries, coalescing) and instance B (4 entries,
// no coalescing) share clock and reset.
module tb_store_buffer_fifo;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic         a_push_valid, a_push_ready, a_drain_valid, a_drain_ready;
    logic [31:0]  a_push_addr, a_drain_addr, a_fwd_addr;
    logic [127:0] a_push_data, a_drain_data, a_fwd_data;
    logic [15:0]  a_push_be, a_drain_be, a_fwd_be, a_fwd_mask;
    logic         a_fwd_valid, a_fwd_hit, a_fwd_partial, a_empty, a_full;
    logic [3:0]   a_count;

    logic         b_push_valid, b_push_ready, b_drain_valid, b_drain_ready;
    logic [31:0]  b_push_addr, b_drain_addr, b_fwd_addr;
    logic [127:0] b_push_data, b_drain_data, b_fwd_data;
    logic [15:0]  b_push_be, b_drain_be, b_fwd_be, b_fwd_mask;
    logic         b_fwd_valid, b_fwd_hit, b_fwd_partial, b_empty, b_full;
    logic [2:0]   b_count;

    store_buffer_fifo #(.NUM_ENTRIES(8), .ADDR_WIDTH(32), .DATA_BYTES(16), .COALESCE(1)) u_a (
        .clock(clock), .reset(reset),
        .push_valid(a_push_valid), .push_ready(a_push_ready), .push_addr(a_push_addr),
        .push_data(a_push_data), .push_be(a_push_be),
        .drain_valid(a_drain_valid), .drain_ready(a_drain_ready), .drain_addr(a_drain_addr),
        .drain_data(a_drain_data), .drain_be(a_drain_be),
        .fwd_valid(a_fwd_valid), .fwd_addr(a_fwd_addr), .fwd_be(a_fwd_be),
        .fwd_hit(a_fwd_hit), .fwd_partial(a_fwd_partial), .fwd_data(a_fwd_data),
        .fwd_mask(a_fwd_mask), .empty(a_empty), .full(a_full), .count(a_count)
    );

    store_buffer_fifo #(.NUM_ENTRIES(4), .ADDR_WIDTH(32), .DATA_BYTES(16), .COALESCE(0)) u_b (
        .clock(clock), .reset(reset),
        .push_valid(b_push_valid), .push_ready(b_push_ready), .push_addr(b_push_addr),
        .push_data(b_push_data), .push_be(b_push_be),
        .drain_valid(b_drain_valid), .drain_ready(b_drain_ready), .drain_addr(b_drain_addr),
        .drain_data(b_drain_data), .drain_be(b_drain_be),
        .fwd_valid(b_fwd_valid), .fwd_addr(b_fwd_addr), .fwd_be(b_fwd_be),
        .fwd_hit(b_fwd_hit), .fwd_partial(b_fwd_partial), .fwd_data(b_fwd_data),
        .fwd_mask(b_fwd_mask), .empty(b_empty), .full(b_full), .count(b_count)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_push(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] be);
        a_push_valid = 1'b1;
        a_push_addr  = addr;
        a_push_data  = data;
        a_push_be    = be;
        tick();
        a_push_valid = 1'b0;
    endtask

    task automatic b_push(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] be);
        b_push_valid = 1'b1;
        b_push_addr  = addr;
        b_push_data  = data;
        b_push_be    = be;
        tick();
        b_push_valid = 1'b0;
    endtask

    logic [31:0] w;
    logic [31:0] exp_q [$];

    initial begin
        reset = 1'b0;
        a_push_valid = 1'b0; a_push_addr = '0; a_push_data = '0; a_push_be = '0;
        a_drain_ready = 1'b0; a_fwd_valid = 1'b0; a_fwd_addr = '0; a_fwd_be = '0;
        b_push_valid = 1'b0; b_push_addr = '0; b_push_data = '0; b_push_be = '0;
        b_drain_ready = 1'b0; b_fwd_valid = 1'b0; b_fwd_addr = '0; b_fwd_be = '0;
        #2;
        // Reset state
        chk("rst_count", 128'(a_count), 128'd0);
        chk("rst_empty", 128'(a_empty), 128'd1);
        chk("rst_full", 128'(a_full), 128'd0);
        chk("rst_drain_valid", 128'(a_drain_valid), 128'd0);
        chk("rst_push_ready", 128'(a_push_ready), 128'd1);
        chk("rst_drain_addr", 128'(a_drain_addr), 128'd0);
        chk("rst_drain_be", 128'(a_drain_be), 128'd0);
        chk("rst_fwd_hit", 128'(a_fwd_hit), 128'd0);
        chk("rst_b_count", 128'(b_count), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Fill A with 8 distinct lines, drain blocked
        for (int i = 0; i < 8; i++) begin
            w = 32'hD000_0000 + 32'(i);
            a_push(32'h1000 + 32'(i * 16), {4{w}}, 16'hFFFF);
        end
        a_push_addr = 32'h9990;
        #1;
        chk("fill_count", 128'(a_count), 128'd8);
        chk("fill_full", 128'(a_full), 128'd1);
        chk("fill_push_ready", 128'(a_push_ready), 128'd0);
        chk("fill_empty", 128'(a_empty), 128'd0);
        a_push_addr = 32'h1074;
        #1;
        chk("full_coalesce_ready", 128'(a_push_ready), 128'd1);
        a_drain_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 32'hD000_0000 + 32'(i);
            chk("drain_valid", 128'(a_drain_valid), 128'd1);
            chk("drain_order_addr", 128'(a_drain_addr), 128'(32'h1000 + 32'(i * 16)));
            chk("drain_order_data", a_drain_data, {4{w}});
            tick();
        end
        a_drain_ready = 1'b0;
        chk("drained_empty", 128'(a_empty), 128'd1);
        chk("drained_valid", 128'(a_drain_valid), 128'd0);

        // Coalesce into youngest entry
        a_push(32'h100, 128'h1111_1111, 16'h000F);
        a_push(32'h104, 128'h2222_2222_0000_0000, 16'h00F0);
        chk("coal_count", 128'(a_count), 128'd1);
        chk("coal_be", 128'(a_drain_be), 128'h00FF);
        chk("coal_data", a_drain_data, 128'h2222_2222_1111_1111);
        chk("coal_addr", 128'(a_drain_addr), 128'h100);
        a_drain_ready = 1'b1;
        tick();
        a_drain_ready = 1'b0;
        chk("coal_drained", 128'(a_empty), 128'd1);

        // Forwarding from the youngest matching entry
        a_push(32'h200, 128'hAA, 16'h0001);
        a_push(32'h300, 128'hCC00, 16'h0002);
        a_push(32'h200, 128'hBB, 16'h0001);
        chk("fwd_setup_count", 128'(a_count), 128'd3);
        a_fwd_valid = 1'b1; a_fwd_addr = 32'h208; a_fwd_be = 16'h0001;
        #1;
        chk("fwd1_hit", 128'(a_fwd_hit), 128'd1);
        chk("fwd1_partial", 128'(a_fwd_partial), 128'd0);
        chk("fwd1_data", a_fwd_data, 128'hBB);
        chk("fwd1_mask", 128'(a_fwd_mask), 128'h0001);
        a_fwd_be = 16'h0003;
        #1;
        chk("fwd2_hit", 128'(a_fwd_hit), 128'd0);
        chk("fwd2_partial", 128'(a_fwd_partial), 128'd1);
        chk("fwd2_mask", 128'(a_fwd_mask), 128'h0001);
        chk("fwd2_data", a_fwd_data, 128'hBB);
        a_fwd_addr = 32'h300; a_fwd_be = 16'h0002;
        #1;
        chk("fwd3_hit", 128'(a_fwd_hit), 128'd1);
        chk("fwd3_data", a_fwd_data, 128'hCC00);
        a_fwd_addr = 32'h500; a_fwd_be = 16'h0001;
        #1;
        chk("fwd_miss_hit", 128'(a_fwd_hit), 128'd0);
        chk("fwd_miss_partial", 128'(a_fwd_partial), 128'd0);
        chk("fwd_miss_mask", 128'(a_fwd_mask), 128'd0);
        a_fwd_valid = 1'b0; a_fwd_addr = 32'h200; a_fwd_be = 16'h0001;
        #1;
        chk("fwd_off_hit", 128'(a_fwd_hit), 128'd0);
        chk("fwd_off_data", a_fwd_data, 128'd0);
        chk("fwd_off_mask", 128'(a_fwd_mask), 128'd0);
        a_drain_ready = 1'b1;
        tick(); tick(); tick();
        a_drain_ready = 1'b0;
        chk("fwd_drained", 128'(a_empty), 128'd1);

        // Matching push while the only entry drains: must allocate
        a_push(32'h400, 128'h5555_5555, 16'h000F);
        chk("hd_count1", 128'(a_count), 128'd1);
        a_drain_ready = 1'b1;
        a_push(32'h404, 128'h6666_6666_0000_0000, 16'h00F0);
        a_drain_ready = 1'b0;
        chk("hd_count", 128'(a_count), 128'd1);
        chk("hd_be", 128'(a_drain_be), 128'h00F0);
        chk("hd_addr", 128'(a_drain_addr), 128'h400);
        chk("hd_data", a_drain_data, 128'h6666_6666_0000_0000);
        a_drain_ready = 1'b1;
        tick();
        a_drain_ready = 1'b0;

        // B: no coalescing, same-line stores take separate entries
        b_push(32'h100, 128'h1111_1111, 16'h000F);
        b_push(32'h104, 128'h2222_2222_0000_0000, 16'h00F0);
        chk("nocoal_count", 128'(b_count), 128'd2);
        chk("nocoal_be", 128'(b_drain_be), 128'h000F);
        b_drain_ready = 1'b1;
        tick();
        chk("nocoal_be2", 128'(b_drain_be), 128'h00F0);
        tick();
        b_drain_ready = 1'b0;
        chk("nocoal_empty", 128'(b_empty), 128'd1);

        // B: 20 cycles of simultaneous push and drain, pointers wrap
        b_push(32'h5000, {4{32'h5000}}, 16'hFFFF);
        exp_q.push_back(32'h5000);
        b_push(32'h5010, {4{32'h5010}}, 16'hFFFF);
        exp_q.push_back(32'h5010);
        b_push_valid = 1'b1;
        b_drain_ready = 1'b1;
        b_push_be = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            w = 32'h5000 + 32'((c + 2) * 16);
            b_push_addr = w;
            b_push_data = {4{w}};
            chk("wrap_addr", 128'(b_drain_addr), 128'(exp_q[0]));
            chk("wrap_data", b_drain_data, {4{exp_q[0]}});
            chk("wrap_ready", 128'(b_push_ready), 128'd1);
            void'(exp_q.pop_front());
            exp_q.push_back(w);
            tick();
            chk("wrap_count", 128'(b_count), 128'd2);
        end
        b_push_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wrap_tail_addr", 128'(b_drain_addr), 128'(exp_q[0]));
            void'(exp_q.pop_front());
            tick();
        end
        b_drain_ready = 1'b0;
        chk("wrap_empty", 128'(b_empty), 128'd1);

        // Reset mid-drain with five entries
        for (int i = 0; i < 5; i++) begin
            a_push(32'h700 + 32'(i * 16), 128'hFF, 16'hFFFF);
        end
        chk("mr_count5", 128'(a_count), 128'd5);
        a_drain_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_count", 128'(a_count), 128'd0);
        chk("mr_drain_valid", 128'(a_drain_valid), 128'd0);
        chk("mr_empty", 128'(a_empty), 128'd1);
        chk("mr_drain_addr", 128'(a_drain_addr), 128'd0);
        a_fwd_valid = 1'b1; a_fwd_addr = 32'h700; a_fwd_be = 16'hFFFF;
        #1;
        chk("mr_fwd_hit", 128'(a_fwd_hit), 128'd0);
        chk("mr_fwd_partial", 128'(a_fwd_partial), 128'd0);
        a_fwd_valid = 1'b0;
        a_drain_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("post_rst_count", 128'(a_count), 128'd0);
        a_push(32'h800, 128'h77, 16'h0001);
        chk("post_rst_push", 128'(a_count), 128'd1);
        chk("post_rst_addr", 128'(a_drain_addr), 128'h800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
